aes_key_schedule_ctrl: RTL and testbench

Sequencer for AES-128 round-key generation. Accepts a 128-bit cipher key, iterates a single-round key-expansion step ten times, and streams round keys 0..10 to the cipher round datapath over a valid/ready handshake. Round constants are generated at run time, so one expansion instance is shared across all rounds. An optional cache replays the last schedule without recomputation.

---
 rtl/aes_key_schedule_ctrl_pkg.sv | 46 ++++
 rtl/aes_key_schedule_ctrl_expand.sv | 29 ++
 rtl/aes_key_schedule_ctrl.sv | 119 +++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared types, constants and byte-level helpers for the AES-128 key schedule controller.
package aes_ks_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } ks_state_t;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // S-box table, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_expand.sv
// One AES-128 key-expansion round: rotWord/SubWord of word 3, rcon into byte 0, chained XOR.
module aes_key_expand_step
  import aes_ks_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w3;
  logic [31:0] rot;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w3  = key[127:96];
  // byte 0 sits in the low bits, so rotWord is a rotate right by one byte
  assign rot = {w3[7:0], w3[31:8]};

  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {24'h000000, rcon};

  assign n0 = key[31:0]   ^ temp;
  assign n1 = key[63:32]  ^ n0;
  assign n2 = key[95:64]  ^ n1;
  assign n3 = key[127:96] ^ n2;

  assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 round-key sequencer streaming keys 0..NR over valid/ready.
// Optional schedule replay cache enabled by defining AES_KS_CACHE_EN.
module aes_key_schedule_ctrl
  import aes_ks_pkg::*;
#(
  parameter int unsigned NR = aes_ks_pkg::NR
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             replay,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_key,
  output logic [3:0]       rk_round,
  output logic             done
);

  ks_state_t        state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] start_key;
  logic [KEY_W-1:0] step_key;
  logic [7:0]       rcon;
  logic [3:0]       round;
  logic             hs;
  logic             last;

  assign hs   = (state == EMIT) && rk_ready;
  assign last = (round == 4'(NR));

  aes_key_expand_step u_step (
    .key      (key_reg),
    .rcon     (rcon),
    .next_key (next_key)
  );

`ifdef AES_KS_CACHE_EN
  logic [KEY_W-1:0] cache [NR+1];
  logic             cache_vld;
  logic             replaying;
  logic             use_cache;

  assign use_cache = replay && cache_vld;

  always_ff @(posedge clk) begin
    if (hs && !replaying) cache[round] <= key_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      replaying <= 1'b0;
    end else if (state == IDLE && start) begin
      replaying <= use_cache;
      if (!use_cache) cache_vld <= 1'b0;
    end else if (hs && last && !replaying) begin
      cache_vld <= 1'b1;
    end
  end

  // during replay the key register is reloaded from the cache instead of the expansion step
  always_comb begin
    start_key = use_cache ? cache[0] : key_in;
    step_key  = replaying ? cache[round + 4'd1] : next_key;
  end
`else
  logic replay_unused;
  assign replay_unused = replay;

  always_comb begin
    start_key = key_in;
    step_key  = next_key;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      rcon    <= RCON[0];
      round   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= EMIT;
            key_reg <= start_key;
            rcon    <= RCON[0];
            round   <= '0;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (last) begin
              state <= FINISH;
            end else begin
              key_reg <= step_key;
              rcon    <= xtime(rcon);
              round   <= round + 4'd1;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rk_valid = (state == EMIT);
  assign busy     = (state == EMIT);
  assign done     = (state == FINISH);
  assign rk_key   = key_reg;
  assign rk_round = round;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench: transaction-level schedule model plus FIPS-197 literal pins.
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         replay;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_key;
  logic [3:0]   rk_round;
  logic         done;

  int compared = 0;
  int mismatched = 0;

  aes_key_schedule_ctrl #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .replay   (replay),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_key   (rk_key),
    .rk_round (rk_round),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sb [256];
  logic [127:0] m_sched [11];
  logic [127:0] m_cache [11];
  logic [127:0] mtmp [11];
  logic [127:0] pin [11];
  logic [127:0] got_key [11];
  logic         m_active = 1'b0;
  logic         m_finish = 1'b0;
  logic         m_rep = 1'b0;
  logic         m_cvalid = 1'b0;
  int           m_idx = 0;
  int           hs_log [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] swap16(input logic [127:0] f);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[8*i +: 8] = f[8*(15-i) +: 8];
    return b;
  endfunction

  // FIPS-197 word-oriented expansion; inputs/outputs in block byte order
  task automatic expand_model(input logic [127:0] kblk, output logic [127:0] s [11]);
    logic [31:0]  w [44];
    logic [127:0] f;
    logic [7:0]   rc;
    logic [31:0]  t;
    f  = swap16(kblk);
    for (int i = 0; i < 4; i++) w[i] = f[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) s[r] = swap16({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_finish <= 1'b0;
      m_idx    <= 0;
      m_cvalid <= 1'b0;
    end else if (m_finish) begin
      m_finish <= 1'b0;
    end else if (m_active) begin
      if (rk_ready) begin
        if (m_idx == 10) begin
          m_active <= 1'b0;
          m_finish <= 1'b1;
          if (!m_rep) begin
            m_cache  <= m_sched;
            m_cvalid <= 1'b1;
          end
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_idx    <= 0;
`ifdef AES_KS_CACHE_EN
      if (replay && m_cvalid) begin
        m_rep   <= 1'b1;
        m_sched <= m_cache;
      end else
`endif
      begin
        m_rep    <= 1'b0;
        m_cvalid <= 1'b0;
        expand_model(key_in, mtmp);
        m_sched  <= mtmp;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rk_valid", 128'(rk_valid), 128'(m_active));
      check("busy", 128'(busy), 128'(m_active));
      check("done", 128'(done), 128'(m_finish));
      if (m_active) begin
        check("rk_round", 128'(rk_round), 128'(m_idx));
        check("rk_key", rk_key, m_sched[m_idx]);
        got_key[m_idx] = rk_key;
        if (rk_ready) hs_log.push_back(int'(rk_round));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_start(input logic [127:0] k, input logic r);
    key_in = k;
    replay = r;
    start  = 1'b1;
    step();
    start  = 1'b0;
    replay = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      n++;
    end
    check(name, 128'(n), 128'd12);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_rk_round"}, 128'(rk_round), 128'd0);
    check({tag, "_rk_key"}, rk_key, 128'd0);
  endtask

  logic [127:0] fips_key, fips_r1, fips_r10, zero_r1, zero_r10;

  initial begin
    rst_n = 1'b1; start = 1'b0; replay = 1'b0; rk_ready = 1'b0; key_in = '0;
    fips_key = swap16(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    fips_r1  = swap16(128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    fips_r10 = swap16(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    zero_r1  = swap16(128'h62636363_62636363_62636363_62636363);
    zero_r10 = swap16(128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    build_sbox();

    expand_model(fips_key, pin);
    check("pin_fips_r1", pin[1], fips_r1);
    check("pin_fips_r10", pin[10], fips_r10);
    expand_model(128'd0, pin);
    check("pin_zero_r1", pin[1], zero_r1);
    check("pin_zero_r10", pin[10], zero_r10);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // back-to-back schedule with no backpressure
    rk_ready = 1'b1;
    run_start(fips_key, 1'b0);
    wait_done("fips_start_to_done");
    check("fips_r1", got_key[1], fips_r1);
    check("fips_r10", got_key[10], fips_r10);

    // random stalls of 0..5 cycles before each handshake
    hs_log.delete();
    rk_ready = 1'b0;
    run_start(fips_key, 1'b0);
    for (int r = 0; r < 11; r++) begin
      rk_ready = 1'b0;
      repeat ($urandom_range(0, 5)) step();
      rk_ready = 1'b1;
      step();
    end
    repeat (2) step();
    check("stall_hs_count", 128'(hs_log.size()), 128'd11);
    for (int i = 0; i < 11; i++) check("stall_hs_round", 128'(hs_log[i]), 128'(i));
    check("stall_r10", got_key[10], fips_r10);

    // start during EMIT and during FINISH must be ignored
    run_start(fips_key, 1'b0);
    repeat (4) step();
    key_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("ignore_start_r10", got_key[10], fips_r10);
    check("ignore_start_idle", 128'(rk_valid), 128'd0);

    // asynchronous reset after the round-4 handshake
    run_start(fips_key, 1'b0);
    repeat (5) step();
    check("pre_reset_round", 128'(rk_round), 128'd5);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    step();
    run_start(128'd0, 1'b0);
    wait_done("zero_start_to_done");
    check("zero_r1", got_key[1], zero_r1);
    check("zero_r10", got_key[10], zero_r10);

    // replay with a different key_in, then a fresh schedule, then replay again
    run_start(fips_key, 1'b1);
    wait_done("replay1_start_to_done");
`ifdef AES_KS_CACHE_EN
    check("replay1_r1", got_key[1], zero_r1);
`else
    check("replay1_r1", got_key[1], fips_r1);
`endif
    run_start(fips_key, 1'b0);
    wait_done("fresh_start_to_done");
    check("fresh_r10", got_key[10], fips_r10);
    run_start(128'd0, 1'b1);
    wait_done("replay2_start_to_done");
`ifdef AES_KS_CACHE_EN
    check("replay2_r10", got_key[10], fips_r10);
`else
    check("replay2_r10", got_key[10], zero_r10);
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
